// File: rtl/syn_down_timer_pkg.sv
// Shared encodings and defaults for the loadable down-counting timer.
package syn_timer_pkg;

    localparam int DEFAULT_BITS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/syn_down_timer_if.sv
// Control/status bundle of the down timer; master drives control, slave is the timer.
interface syn_down_timer_if
    import syn_timer_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
);
    logic            load;
    logic [BITS-1:0] load_val;
    logic            start;
    logic            stop;
    logic            periodic;
    logic [BITS-1:0] count;
    logic            busy;
    logic            done;
    logic            tc;

    modport master (
        output load, load_val, start, stop, periodic,
        input  count, busy, done, tc
    );

    modport slave (
        input  load, load_val, start, stop, periodic,
        output count, busy, done, tc
    );
endinterface

// File: rtl/syn_down_timer_counter.sv
// Count register of the timer: load beats reload beats decrement; never goes below zero.
module syn_nbit_down_counter
    import syn_timer_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [BITS-1:0] i_load_val,
    input  logic            i_reload,
    input  logic [BITS-1:0] i_reload_val,
    input  logic            i_dec,
    output logic [BITS-1:0] o_count,
    output logic            o_is_one,
    output logic            o_is_zero
);
    logic [BITS-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_reload) begin
            r_count <= i_reload_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - BITS'(1);
        end
    end

    assign o_count   = r_count;
    assign o_is_one  = (r_count == BITS'(1));
    assign o_is_zero = (r_count == '0);
endmodule

// File: rtl/syn_down_timer.sv
// Down timer top: IDLE/RUN/DONE control FSM, reload register and registered status flags.
module syn_down_timer
    import syn_timer_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
) (
    input logic             clk,
    input logic             rst,
    syn_down_timer_if.slave bus
);
    state_t          r_state;
    state_t          w_state_next;
    logic [BITS-1:0] r_reload;
    logic            r_busy;
    logic            r_done;
    logic            r_tc;

    logic            w_is_one;
    logic            w_is_zero;
    logic            w_cnt_reload;
    logic            w_cnt_dec;
    logic            w_tc_next;
    logic            w_run_step;
    logic            w_start_ok;

    syn_nbit_down_counter #(.BITS(BITS)) u_counter (
        .clk          (clk),
        .rst          (rst),
        .i_load       (bus.load),
        .i_load_val   (bus.load_val),
        .i_reload     (w_cnt_reload),
        .i_reload_val (r_reload),
        .i_dec        (w_cnt_dec),
        .o_count      (bus.count),
        .o_is_one     (w_is_one),
        .o_is_zero    (w_is_zero)
    );

    // State, reload and flags; flags follow the next state so they are valid with the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_reload <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_tc     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == RUN);
            r_done  <= (w_state_next == DONE);
            r_tc    <= w_tc_next;
            if (bus.load) begin
                r_reload <= bus.load_val;
            end
        end
    end

    // A stop masks a coincident start, a load masks both.
    assign w_start_ok = !bus.load && !bus.stop && bus.start;
    assign w_run_step = (r_state == RUN) && !bus.load && !bus.stop;

    always_comb begin
        w_state_next = r_state;
        if (bus.load) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: if (w_start_ok && !w_is_zero) w_state_next = RUN;
                RUN: begin
                    if (bus.stop) begin
                        w_state_next = IDLE;
                    end else if (w_is_one && !bus.periodic) begin
                        w_state_next = DONE;
                    end
                end
                DONE:    if (w_start_ok && (r_reload != '0)) w_state_next = RUN;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        w_cnt_reload = (w_run_step && w_is_one && bus.periodic)
                    || ((r_state == DONE) && w_start_ok && (r_reload != '0));
        w_cnt_dec    = w_run_step && !(w_is_one && bus.periodic);
        w_tc_next    = w_run_step && w_is_one;
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.tc   = r_tc;
endmodule

// File: tb/tb_syn_down_timer.sv
// Directed bench for syn_down_timer at BITS=8 with hand-computed expectations.
module tb_syn_down_timer;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    syn_down_timer_if #(.BITS(8)) bus ();

    syn_down_timer #(.BITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] v);
        bus.load     = 1'b1;
        bus.load_val = v;
        tick();
        idle_inputs();
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        logic [7:0] per_exp [9];
        int pulses;
        int cycles;
        bit seen;

        n_tests = 0;
        n_fail  = 0;
        per_exp = '{8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3, 8'd2, 8'd1, 8'd3};
        rst = 1'b1;
        idle_inputs();
        bus.load_val = '0;
        bus.periodic = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check_val("rst_count", bus.count, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_done", bus.done, 0);
        check_val("rst_tc", bus.tc, 0);
        $display("[TB] reset checked");

        // One-shot 5
        do_load(8'd5);
        check_val("os_load_count", bus.count, 5);
        check_val("os_load_busy", bus.busy, 0);
        do_start();
        check_val("os_start_count", bus.count, 5);
        check_val("os_start_busy", bus.busy, 1);
        for (int i = 4; i >= 1; i--) begin
            tick();
            check_val("os_count", bus.count, 32'(i));
            check_val("os_tc_low", bus.tc, 0);
        end
        tick();
        check_val("os_zero_count", bus.count, 0);
        check_val("os_tc", bus.tc, 1);
        check_val("os_done", bus.done, 1);
        check_val("os_busy_low", bus.busy, 0);
        tick();
        check_val("os_tc_drop", bus.tc, 0);
        check_val("os_done_hold", bus.done, 1);
        check_val("os_count_hold", bus.count, 0);
        do_start();
        check_val("os_restart_count", bus.count, 5);
        check_val("os_restart_busy", bus.busy, 1);
        check_val("os_restart_done", bus.done, 0);
        $display("[TB] one-shot checked");

        // Periodic 3
        do_load(8'd3);
        check_val("per_load_idle", bus.busy, 0);
        bus.periodic = 1'b1;
        do_start();
        check_val("per_start_count", bus.count, 3);
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            check_val("per_count", bus.count, 32'(per_exp[i]));
            check_val("per_tc", bus.tc, (per_exp[i] == 8'd3) ? 1 : 0);
            if (bus.tc) pulses++;
        end
        check_val("per_pulses", pulses, 3);
        check_val("per_busy", bus.busy, 1);

        // Reload of 1: tc held high
        do_load(8'd1);
        do_start();
        check_val("r1_start_count", bus.count, 1);
        check_val("r1_start_tc", bus.tc, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("r1_count", bus.count, 1);
            check_val("r1_tc", bus.tc, 1);
        end
        bus.periodic = 1'b0;
        $display("[TB] periodic checked");

        // Pause / resume
        do_load(8'd10);
        do_start();
        repeat (4) tick();
        check_val("pr_before_stop", bus.count, 6);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check_val("pr_stop_count", bus.count, 6);
        check_val("pr_stop_busy", bus.busy, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("pr_hold_count", bus.count, 6);
            check_val("pr_hold_busy", bus.busy, 0);
        end
        do_start();
        check_val("pr_resume_count", bus.count, 6);
        check_val("pr_resume_busy", bus.busy, 1);
        for (int i = 5; i >= 1; i--) begin
            tick();
            check_val("pr_count", bus.count, 32'(i));
        end
        tick();
        check_val("pr_end_count", bus.count, 0);
        check_val("pr_end_tc", bus.tc, 1);
        $display("[TB] pause/resume checked");

        // Simultaneous controls
        do_load(8'd20);
        do_start();
        tick();
        check_val("sim_run_count", bus.count, 19);
        bus.stop  = 1'b1;
        bus.start = 1'b1;
        tick();
        idle_inputs();
        check_val("sim_pause_count", bus.count, 19);
        check_val("sim_pause_busy", bus.busy, 0);
        bus.load     = 1'b1;
        bus.load_val = 8'd200;
        bus.stop     = 1'b1;
        bus.start    = 1'b1;
        tick();
        idle_inputs();
        check_val("sim_load_count", bus.count, 200);
        check_val("sim_load_busy", bus.busy, 0);
        tick();
        check_val("sim_idle_hold", bus.count, 200);
        do_load(8'd0);
        do_start();
        check_val("sim_zero_busy", bus.busy, 0);
        check_val("sim_zero_tc", bus.tc, 0);
        check_val("sim_zero_done", bus.done, 0);
        $display("[TB] simultaneous controls checked");

        // Asynchronous reset mid-count
        do_load(8'd40);
        do_start();
        repeat (3) tick();
        check_val("ar_pre_count", bus.count, 37);
        #2 rst = 1'b1;
        #1;
        check_val("ar_count", bus.count, 0);
        check_val("ar_busy", bus.busy, 0);
        check_val("ar_done", bus.done, 0);
        check_val("ar_tc", bus.tc, 0);
        tick();
        rst = 1'b0;
        repeat (2) tick();
        check_val("ar_after_count", bus.count, 0);
        check_val("ar_after_busy", bus.busy, 0);
        do_start();
        check_val("ar_start_ignored", bus.busy, 0);
        $display("[TB] async reset checked");

        // Boundary 255 one-shot
        do_load(8'd255);
        do_start();
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 300) begin
            tick();
            cycles++;
            if (bus.tc) seen = 1'b1;
        end
        check_val("b255_cycles", cycles, 255);
        check_val("b255_count", bus.count, 0);
        check_val("b255_done", bus.done, 1);
        tick();
        check_val("b255_no_wrap", bus.count, 0);
        check_val("b255_tc_drop", bus.tc, 0);
        $display("[TB] boundary checked");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/syn_down_timer.md
# syn_down_timer

Synchronous loadable N-bit down-counting timer with a small control FSM. It counts a programmed value down to zero and raises a single-cycle terminal-count pulse. It supports one-shot and periodic (auto-reload) modes, pause/resume, and restart. It is the count-down complement of the team's free-running up counter, used for timeouts and periodic ticks.

## Interface
- BITS, 32, width of count, load value and reload register
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- load  in  1  write load_val into count and reload register
- load_val  in  BITS  value written by load
- start  in  1  begin counting, resume after pause, or restart from DONE
- stop  in  1  pause counting; count holds
- periodic  in  1  1 = auto-reload at terminal count, 0 = one-shot; sampled only at the terminal edge
- count  out  BITS  current count (registered)
- busy  out  1  high while in RUN
- done  out  1  high while in DONE (one-shot expired)
- tc  out  1  one-cycle registered terminal-count pulse

## Operation
- Reset (async, rst=1) forces: count=0, reload=0, state IDLE, busy=0, done=0, tc=0.
- Control priority when inputs coincide: load > stop > start.
- load, any state: count<=load_val, reload<=load_val, state->IDLE, tc=0. The current run is aborted.
- IDLE: count holds.
  - start with count!=0 -> RUN.
  - start with count==0 is ignored; the block stays in IDLE with no tc.
- RUN, each edge without load/stop:
  - count>1: count<=count-1.
  - count==1, periodic=1: count<=reload, tc<=1, stay in RUN. Count never shows 0.
  - count==1, periodic=0: count<=0, tc<=1, state->DONE.
- stop in RUN -> IDLE with count held and no decrement that edge; a later start resumes from the held value.
- stop in IDLE or DONE has no effect.
- DONE: count=0 and done=1.
  - start with reload!=0: count<=reload, state->RUN.
  - start with reload==0 is ignored.
- Count never wraps: no decrement below 0.
- reload==1 in periodic mode: count stays 1 and tc is high every cycle.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- load sampled at edge k: count=load_val after edge k.
- start sampled at edge k with count N: busy=1 after edge k, first decrement at edge k+1.
- One-shot: count reaches 0, tc=1 and done=1 after edge k+N. tc drops after edge k+N+1.
- Periodic with reload R: tc pulses once every R cycles after the first N.
- tc is high for exactly one cycle per terminal event. The only exception is R==1, where tc stays high continuously.
- rst asserted mid-run clears all outputs immediately, without waiting for clk. The block restarts from IDLE on the first edge after rst deasserts.

## Structure
- Package syn_timer_pkg holds:
  - the state encoding IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - the default BITS constant.
- Sub-module syn_nbit_down_counter holds the datapath:
  - count register with load, reload and decrement controls;
  - is_one flag output.
- The top level holds the FSM, the reload register and the tc/busy/done registers.

## Test plan
All scenarios use BITS=8.
- Reset: rst=1 mid-count at count=37 -> count=0, busy=0, done=0, tc=0 without waiting for a clk edge. Outputs stay cleared until start.
- One-shot: load 5, start, periodic=0 -> count 5,4,3,2,1,0.
  - tc high one cycle, aligned with count=0.
  - done=1 and busy=0 from then on.
  - start again -> count 5 and RUN.
- Periodic: load 3, start, periodic=1 -> count 3,2,1,3,2,1,3…
  - tc high in each cycle count=3 is shown after reload.
  - 3 pulses in 9 cycles.
  - R=1 case: tc continuously high.
- Pause/resume: load 10, start, stop at count=6 -> count holds 6 for 4 cycles with busy=0. start -> 6,5,…,0 and tc.
- Simultaneous events:
  - load(200)+stop+start in one cycle -> count=200, IDLE.
  - stop+start in RUN -> pause wins.
  - start with count=0 in IDLE -> no state change, no tc.
- Boundary: load 255, start, one-shot -> exactly 255 decrements, tc after 255 cycles, no wrap to 255.
